cby_cfg_dbuf: RTL
=================

# cby_cfg_dbuf

Parametrised Y-channel connection block with a double-buffered configuration chain. Routes `CHAN_W` vertical tracks straight through between top and bottom. Drives `NUM_IPIN` grid input pins through `MUX_SIZE`-input selectors. Configuration bits shift into a shadow chain while the selectors keep running on the previously committed configuration. The new configuration is committed atomically, and only after a complete bitstream has been loaded, so there is no glitch-prone partial reconfiguration.

## Interface
Parameters:
- `CHAN_W`, default 20: tracks per direction. Must be divisible by `MUX_SIZE/2`.
- `NUM_IPIN`, default 9: number of grid input pins driven.
- `MUX_SIZE`, default 8: selector inputs per pin. Must be even and ≥2.
- `SEL_W`, derived as `$clog2(MUX_SIZE)`: select bits per pin.
- `L`, derived as `NUM_IPIN*SEL_W`: chain length (default 27).

Ports:
- `prog_clk` input, 1 bit: the only clock.
- `pReset` input, 1 bit: reset, synchronous, active-high.
- `config_enable` input, 1 bit: shift enable for the configuration chain.
- `ccff_head` input, 1 bit: serial configuration data in.
- `chany_bottom_in` input, `CHAN_W` bits: tracks entering from the bottom.
- `chany_top_in` input, `CHAN_W` bits: tracks entering from the top.
- `chany_bottom_out` output, `CHAN_W` bits: equals `chany_top_in`, combinational.
- `chany_top_out` output, `CHAN_W` bits: equals `chany_bottom_in`, combinational.
- `ipin_out` output, `NUM_IPIN` bits: selected track per grid pin.
- `ccff_tail` output, 1 bit: serial data out, which is `chain[L-1]`.
- `cfg_done` output, 1 bit: high while the shift counter equals `L`.
- `cfg_commit` output, 1 bit: one-cycle pulse when the shadow chain is copied to the active registers.
- `cfg_err` output, 1 bit: one-cycle pulse when a shift ends before `L` bits have been shifted.

## Operation

**Shadow chain**
- The shadow chain is `chain[0:L-1]`.
- On each edge with `config_enable`=1: `chain[0]<=ccff_head` and `chain[k]<=chain[k-1]`.
- Pin m's select field is `chain[m*SEL_W +: SEL_W]`. The lowest index in the field is the MSB.
- Consequently, the last bit shifted in becomes the MSB of pin 0.

**Active registers**
- Active registers `act_sel[m]` drive the selectors.
- They change only on a commit or on reset.

**Selector mapping**
- `TAPS = MUX_SIZE/2`, `STRIDE = CHAN_W/TAPS`.
- For pin i and tap j, the track is `t = (i + j*STRIDE) mod CHAN_W`.
- Selector input `2j` is `chany_bottom_in[t]`; selector input `2j+1` is `chany_top_in[t]`.
- If `act_sel >= MUX_SIZE`, `ipin_out[i]` is 0 (only possible when `MUX_SIZE` is not a power of two).

**Shift counter**
- `cnt` is `$clog2(L+1)` bits wide.
- It increments on each shift and saturates at `L`.
- Shifting past `L` remains legal: extra bits overflow out through `ccff_tail`.

**FSM**
- IDLE → SHIFT on an edge with `config_enable`=1. This same edge performs the first shift and sets `cnt` to 1.
- SHIFT → SHIFT while `config_enable`=1.
- SHIFT → IDLE on the first edge with `config_enable`=0:
  - If `cnt==L`: `act_sel<=shadow` and `cfg_commit<=1`.
  - Otherwise: `cfg_err<=1` and `act_sel` is unchanged.
  - In both cases `cnt<=0`.
- The shadow chain is never cleared on exit, so it stays readable through `ccff_tail`.

**Reset (`pReset`=1 at an edge)**
- The chain, `act_sel`, and `cnt` go to 0; the FSM goes to IDLE.
- `cfg_done`, `cfg_commit`, and `cfg_err` go to 0.
- `ccff_tail` goes to 0.
- `ipin_out` therefore selects input 0: `ipin_out[i] = chany_bottom_in[i mod CHAN_W]`.
- Reset takes priority over `config_enable`. Reset in the middle of a shift aborts with no commit and no `cfg_err`.

## Timing
- Passthrough paths and selector outputs are combinational from their inputs and from `act_sel`.
- Shift latency: a bit presented on `ccff_head` at edge n appears on `ccff_tail` after edge n+L-1, and is observable before edge n+L.
- Commit latency: on the edge that samples `config_enable`=0 with `cnt==L`, the new `ipin_out` and the `cfg_commit`=1 pulse are both visible right after that edge. The pulse lasts exactly one cycle.
- `cfg_done` is registered. It rises after the edge that makes `cnt==L`, and falls after the commit edge.
- Re-asserting `config_enable` on the cycle right after a commit or error is legal. The counter restarts from 0 on that edge.

## Test plan
1. **Reset.** Assert `pReset` for 2 edges with random channel inputs. Then `ipin_out[0]=chany_bottom_in[0]`, `ipin_out[8]=chany_bottom_in[8]`, `ccff_tail`=0, and all status outputs are 0. The passthroughs mirror the inputs.
2. **Full load.** Defaults. Shift 24 zeros, then 1, 1, 0 (27 shifts), then deassert. `cfg_done`=1 before deassert. `cfg_commit` pulses once. `ipin_out[0]` follows `chany_top_in[5]`; the other pins follow `chany_bottom_in[i]`.
3. **Hitless reconfiguration.** With the case-2 configuration active, toggle `chany_top_in[5]` during a second 27-bit load. `ipin_out[0]` tracks `chany_top_in[5]` on every cycle until the commit edge.
4. **Aborted load.** Shift 10 bits, then deassert. `cfg_err` pulses once, `cfg_commit` stays 0, `act_sel` is unchanged, and `cnt` returns to 0.
5. **Readback/overflow.** Shift 27 bits of pattern `1,0,0,…`, then 3 more zeros. `ccff_tail`=1 only in the cycle following shift 27. A commit still occurs with `cnt` saturated at 27.
6. **Reset mid-shift.** Assert `pReset` after shift 15. Result is IDLE, `cnt`=0, no `cfg_err` and no `cfg_commit`, and `ipin_out` is back at the reset mapping.

Source files
------------

// File: rtl/cby_cfg_dbuf.sv
// cby_cfg_dbuf: Y-channel connection block with a double-buffered configuration chain.
// Tracks pass straight through top<->bottom; each grid input pin picks one of MUX_SIZE
// taps using a committed select field. New configuration shifts into a shadow chain
// and is copied to the active registers only after exactly L bits have been loaded.
//
// Ports:
//   prog_clk          clock
//   pReset            synchronous active-high reset
//   config_enable     shift enable for the shadow chain
//   ccff_head         serial configuration input
//   chany_bottom_in   tracks entering from the bottom
//   chany_top_in      tracks entering from the top
//   chany_bottom_out  = chany_top_in (combinational)
//   chany_top_out     = chany_bottom_in (combinational)
//   ipin_out          selected track per grid pin (combinational from act_sel/tracks)
//   ccff_tail         last bit of the shadow chain
//   cfg_done          high while the shift counter holds L
//   cfg_commit        one-cycle pulse when shadow is copied to active
//   cfg_err           one-cycle pulse when a shift burst ends short of L bits
module cby_cfg_dbuf #(
  parameter int unsigned CHAN_W   = 20,
  parameter int unsigned NUM_IPIN = 9,
  parameter int unsigned MUX_SIZE = 8
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                config_enable,
  input  logic                ccff_head,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_done,
  output logic                cfg_commit,
  output logic                cfg_err
);

  localparam int unsigned SEL_W  = $clog2(MUX_SIZE);
  localparam int unsigned L      = NUM_IPIN * SEL_W;
  localparam int unsigned CNT_W  = $clog2(L + 1);
  localparam int unsigned TAPS   = MUX_SIZE / 2;
  localparam int unsigned STRIDE = CHAN_W / TAPS;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [L-1:0]     chain_q, chain_d;
  logic [L-1:0]     act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             commit_q, commit_d;
  logic             err_q, err_d;
  logic [L-1:0]     chain_shifted;

  // Straight-through tracks
  assign chany_bottom_out = chany_top_in;
  assign chany_top_out    = chany_bottom_in;

  assign ccff_tail  = chain_q[L-1];
  assign cfg_done   = done_q;
  assign cfg_commit = commit_q;
  assign cfg_err    = err_q;

  // chain[0] takes the new bit, every other bit moves one place toward the tail
  assign chain_shifted = (chain_q << 1) | L'(ccff_head);

  // Next-state: shifting, commit/abort decision, saturating counter
  always_comb begin
    state_d  = state_q;
    chain_d  = chain_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (config_enable) begin
          chain_d = chain_shifted;
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (config_enable) begin
          chain_d = chain_shifted;
          if (cnt_q != CNT_W'(L)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (cnt_q == CNT_W'(L)) begin
            act_d    = chain_q;
            commit_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (cnt_d == CNT_W'(L));
  end

  // State registers
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q  <= ST_IDLE;
      chain_q  <= '0;
      act_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chain_q  <= chain_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  // Per-pin selectors: input 2j = bottom track t, 2j+1 = top track t
  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [SEL_W-1:0]    pin_sel;
    logic [MUX_SIZE-1:0] mux_in;
    logic                pin_bit;

    // Lowest chain index in the field is the select MSB
    for (genvar b = 0; b < SEL_W; b++) begin : g_bit
      assign pin_sel[SEL_W-1-b] = act_q[i*SEL_W + b];
    end

    for (genvar j = 0; j < TAPS; j++) begin : g_tap
      localparam int unsigned T = (i + j * STRIDE) % CHAN_W;
      assign mux_in[2*j]   = chany_bottom_in[T];
      assign mux_in[2*j+1] = chany_top_in[T];
    end

    // Out-of-range selects (non power-of-two MUX_SIZE) drive 0
    always_comb begin
      pin_bit = 1'b0;
      if ({1'b0, pin_sel} < (SEL_W+1)'(MUX_SIZE)) begin
        pin_bit = mux_in[pin_sel];
      end
    end

    assign ipin_out[i] = pin_bit;
  end

endmodule
